video_timing_gen: RTL and testbench

Pixel-domain raster timing generator driven by the 32 MHz pixel clock and lock flag of `sys_pll`. It waits for a stable PLL lock, then produces hsync, vsync, data-enable and pixel coordinates for an 800x480 panel at 928x525 total, about 65.7 Hz. It is the first stage of the video path. Downstream blocks (frame-buffer reader, pattern generator) use `frame_start`, `de`, `x` and `y` to fetch or produce pixels.

---
 rtl/video_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Lock-gated raster timing generator (hsync/vsync/de/x/y/pulses)
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_DISP      = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 40,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 29,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_SETTLE = 1024
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        pll_locked,
    output logic        running,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [10:0] c_H_DISP     = 11'(H_DISP);
    localparam logic [10:0] c_HS_START   = 11'(H_DISP + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] c_H_LAST     = 11'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_V_DISP     = 10'(V_DISP);
    localparam logic [9:0]  c_VS_START   = 10'(V_DISP + V_FP);
    localparam logic [9:0]  c_VS_END     = 10'(V_DISP + V_FP + V_SYNC);
    localparam logic [9:0]  c_V_LAST     = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam int          c_SW         = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(LOCK_SETTLE - 1);
    localparam logic [c_SW-1:0] c_SETTLE_ONE  = c_SW'(1);
    localparam logic        c_HS_ON      = HS_POL;
    localparam logic        c_HS_OFF     = ~HS_POL;
    localparam logic        c_VS_ON      = VS_POL;
    localparam logic        c_VS_OFF     = ~VS_POL;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_lock_meta;
    logic              r_lock_sync;
    logic [c_SW-1:0]   r_settle_cnt;
    logic [c_SW-1:0]   w_settle_next;
    logic [10:0]       r_h_cnt;
    logic [10:0]       w_h_next;
    logic [9:0]        r_v_cnt;
    logic [9:0]        w_v_next;
    logic              w_run;
    logic              w_de;
    logic              w_hs_act;
    logic              w_vs_act;

    // pll_locked comes from another clock domain
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT_LOCK;
            r_settle_cnt <= '0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_h_cnt      <= w_h_next;
            r_v_cnt      <= w_v_next;
        end
    end

    // Counters read as zero whenever the next state is not RUN
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = '0;
        w_h_next      = '0;
        w_v_next      = '0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_lock_sync) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!r_lock_sync) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_settle_next = r_settle_cnt + c_SETTLE_ONE;
                end
            end
            ST_RUN: begin
                if (!r_lock_sync) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_h_cnt == c_H_LAST) begin
                    w_v_next = (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    w_h_next = r_h_cnt + 11'd1;
                    w_v_next = r_v_cnt;
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
            end
        endcase
    end

    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_de     = w_run && (r_h_cnt < c_H_DISP) && (r_v_cnt < c_V_DISP);
        w_hs_act = w_run && (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
        w_vs_act = w_run && (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    end

    // running tracks the state register; the rest lag the counters by one cycle
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            hsync       <= c_HS_OFF;
            vsync       <= c_VS_OFF;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= (w_state_next == ST_RUN);
            hsync       <= w_hs_act ? c_HS_ON : c_HS_OFF;
            vsync       <= w_vs_act ? c_VS_ON : c_VS_OFF;
            de          <= w_de;
            x           <= w_de ? r_h_cnt : 11'd0;
            y           <= w_de ? r_v_cnt : 10'd0;
            line_start  <= w_de && (r_h_cnt == 11'd0);
            frame_start <= w_de && (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Scoreboard bench for video_timing_gen on a reduced 28x13 raster
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        pll_locked = 1'b0;

    logic        running, hsync, vsync, de, line_start, frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic        running2, hsync2, vsync2, de2, line_start2, frame_start2;
    logic [10:0] x2;
    logic [9:0]  y2;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    video_timing_gen #(
        .H_DISP(16), .H_FP(4), .H_SYNC(5), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_SETTLE(16)
    ) u_dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .running(running), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    video_timing_gen #(
        .H_DISP(16), .H_FP(4), .H_SYNC(5), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_SETTLE(16)
    ) u_dut_pol (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .running(running2), .hsync(hsync2), .vsync(vsync2), .de(de2),
        .x(x2), .y(y2), .line_start(line_start2), .frame_start(frame_start2)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
    endtask

    task automatic push1(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q1.push_back(e);
    endtask

    task automatic push2(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q2.push_back(e);
    endtask

    task automatic observe1(input string tag, input int val);
        exp_t e;
        if (q1.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event value %0d at edge %0d", tag, val, cyc);
        end else begin
            e = q1.pop_front();
            if (e.tag != tag) begin
                n_checks++;
                $display("FAIL %s: got event %s=%0d, expected %s=%0d (edge %0d)",
                         e.tag, tag, val, e.tag, e.val, cyc);
            end else begin
                check(tag, val, e.val);
            end
        end
    endtask

    task automatic observe2(input string tag, input int val);
        exp_t e;
        if (q2.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event value %0d at edge %0d", tag, val, cyc);
        end else begin
            e = q2.pop_front();
            if (e.tag != tag) begin
                n_checks++;
                $display("FAIL %s: got event %s=%0d, expected %s=%0d (edge %0d)",
                         e.tag, tag, val, e.tag, e.val, cyc);
            end else begin
                check(tag, val, e.val);
            end
        end
    endtask

    // Raster 28x13: hsync at 20..24, vsync on lines 8..10, 364 cycles per frame
    task automatic push_frame(input int fs_edge, input int n);
        if (n >= 1) push1("fs", fs_edge);
        if (n >= 2) push1("fs_xy", 1);
        if (n >= 3) push1("hs_off", 20);
        if (n >= 4) begin
            push1("hs_w", 5);
            push2("hs2_w", 5);
        end
        if (n >= 5) push1("line_per", 28);
        if (n >= 9) begin
            push1("frame_de", 96);
            push1("frame_lines", 6);
            push1("vs_off", 224);
            push1("vs_w", 84);
            push2("vs2_w", 84);
        end
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge pixel_clk);
    endtask

    bit p_running = 0, p_hs = 0, p_vs = 0, idle_pend = 0, hs_armed = 0, lp_armed = 0;
    bit hs_act, vs_act;
    int fs_edge = 0, ls_edge = 0, hs_rise = 0, vs_rise = 0, de_cnt = 0, line_cnt = 0;

    always @(negedge pixel_clk) begin
        hs_act = (hsync == 1'b0);
        vs_act = (vsync == 1'b0);
        if (idle_pend) begin
            observe1("idle", int'({hsync, vsync, de, line_start, frame_start, (x != 11'd0), (y != 10'd0)}));
            idle_pend = 0;
        end
        if (running && !p_running) observe1("run_rise", cyc);
        if (!running && p_running) begin
            observe1("run_fall", cyc);
            idle_pend = 1;
        end
        if (frame_start) begin
            observe1("fs", cyc);
            observe1("fs_xy", int'(de) + 2 * int'(x) + 4096 * int'(y));
            fs_edge  = cyc;
            de_cnt   = 0;
            line_cnt = 0;
            hs_armed = 1;
            lp_armed = 1;
        end
        if (de) de_cnt++;
        if (line_start) begin
            line_cnt++;
            if (line_cnt == 2 && lp_armed) begin
                observe1("line_per", cyc - ls_edge);
                lp_armed = 0;
            end
            ls_edge = cyc;
        end
        if (hs_act && !p_hs) begin
            hs_rise = cyc;
            if (hs_armed) observe1("hs_off", cyc - ls_edge);
        end
        if (!hs_act && p_hs && hs_armed) begin
            observe1("hs_w", cyc - hs_rise);
            hs_armed = 0;
        end
        if (vs_act && !p_vs) begin
            observe1("frame_de", de_cnt);
            observe1("frame_lines", line_cnt);
            observe1("vs_off", cyc - fs_edge);
            vs_rise = cyc;
        end
        if (!vs_act && p_vs) observe1("vs_w", cyc - vs_rise);
        p_running = running;
        p_hs      = hs_act;
        p_vs      = vs_act;
    end

    bit p_running2 = 0, p_hs2 = 0, p_vs2 = 0, idle_pend2 = 0, hs2_armed = 0;
    int hs2_rise = 0, vs2_rise = 0;

    always @(negedge pixel_clk) begin
        if (idle_pend2) begin
            observe2("idle2", int'({hsync2, vsync2, de2}));
            idle_pend2 = 0;
        end
        if (!running2 && p_running2) idle_pend2 = 1;
        if (frame_start2) hs2_armed = 1;
        if (hsync2 && !p_hs2) hs2_rise = cyc;
        if (!hsync2 && p_hs2 && hs2_armed) begin
            observe2("hs2_w", cyc - hs2_rise);
            hs2_armed = 0;
        end
        if (vsync2 && !p_vs2) vs2_rise = cyc;
        if (!vsync2 && p_vs2) observe2("vs2_w", cyc - vs2_rise);
        p_running2 = running2;
        p_hs2      = hsync2;
        p_vs2      = vsync2;
    end

    initial begin
        wait_until(3);
        reset_n = 1'b1;
        check("reset_ctl", int'({running, hsync, vsync, de, line_start, frame_start}), 24);
        check("reset_x", int'(x), 0);
        check("reset_y", int'(y), 0);
        check("reset_pol", int'({running2, hsync2, vsync2, de2}), 0);

        // Lock sampled at edge 10: RUN at 28, first pixel at 29
        push1("run_rise", 28);
        push_frame(29, 9);
        push_frame(393, 9);
        push_frame(757, 5);
        wait_until(9);
        pll_locked = 1'b1;

        // Loss sampled at edge 849 while showing pixel (8,3)
        wait_until(848);
        push1("run_fall", 851);
        push1("idle", 96);
        push2("idle2", 0);
        pll_locked = 1'b0;

        // Relock, then a 3-cycle dropout inside SETTLE; high again sampled at 876
        wait_until(860);
        push1("run_rise", 894);
        push_frame(895, 9);
        push_frame(1259, 2);
        pll_locked = 1'b1;
        wait_until(872);
        pll_locked = 1'b0;
        wait_until(875);
        pll_locked = 1'b1;

        // Asynchronous reset mid-line at pixel (4,0)
        wait_until(1263);
        push1("run_fall", 1264);
        push1("idle", 96);
        push2("idle2", 0);
        #2;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        #1;
        check("async_ctl", int'({running, hsync, vsync, de, line_start, frame_start}), 24);
        check("async_x", int'(x), 0);
        check("async_y", int'(y), 0);
        check("async_pol", int'({running2, hsync2, vsync2, de2}), 0);
        wait_until(1270);
        reset_n = 1'b1;

        wait_until(1279);
        push1("run_rise", 1298);
        push_frame(1299, 9);
        push_frame(1663, 2);
        pll_locked = 1'b1;

        wait_until(1670);
        check("q1_left", q1.size(), 0);
        check("q2_left", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
